clip_signed_stream: RTL and testbench
=====================================

Name: clip_signed_stream

Overview:
Multi-channel, pipelined signed clipper with valid/ready streaming on both sides. Each of P_NCH lanes is clipped between a shared, run-time programmable lower and upper limit, and each lane is flagged when clipping occurs. Per-lane saturating counters record high-side and low-side clip events. The block sits in the DSP datapath between the filter and decimation stages, and its limits and counters are driven from the slow-control register map.

Parameters:
- P_WIDTH, 16, signed sample width per lane (minimum 2).
- P_NCH, 4, number of lanes (minimum 1).
- P_CNT_WIDTH, 16, width of each clip-event counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lim_lo  in  P_WIDTH  signed lower limit candidate.
- lim_hi  in  P_WIDTH  signed upper limit candidate.
- lim_wr  in  1  1-cycle strobe to load lim_lo/lim_hi.
- lim_err  out  1  1-cycle pulse: last lim_wr rejected.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  P_NCH*P_WIDTH  lanes packed; lane k at [k*P_WIDTH +: P_WIDTH].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  P_NCH*P_WIDTH  clipped lanes, same packing as in_data.
- out_clip_hi  out  P_NCH  per-lane flag: sample exceeded the active upper limit.
- out_clip_lo  out  P_NCH  per-lane flag: sample was below the active lower limit.
- cnt_sel  in  clog2(P_NCH) (min 1)  lane select for counter readback.
- cnt_hi  out  P_CNT_WIDTH  high-side clip count of the selected lane.
- cnt_lo  out  P_CNT_WIDTH  low-side clip count of the selected lane.
- cnt_clr  in  1  synchronous clear of all counters.

Behaviour:
- Reset values:
  - Active limits reset to pass-through: lo = signed min (100..0), hi = signed max (011..1).
  - out_valid, out_data, out_clip_hi, out_clip_lo, lim_err and all counters reset to 0.
  - in_ready is 1 after reset.
- Limit update:
  - On lim_wr with signed lim_lo <= lim_hi, the active limits update at that clock edge.
  - Beats accepted on the same edge use the old limits; beats accepted from the next cycle use the new limits.
  - lim_lo == lim_hi is legal: every output lane equals that value.
  - lim_wr with lim_lo > lim_hi is rejected: active limits are unchanged and lim_err pulses high for 1 cycle.
- Per-lane function (all comparisons signed, full P_WIDTH, no truncation):
  - a > hi: y = hi, clip_hi = 1.
  - a < lo: y = lo, clip_lo = 1.
  - Otherwise: y = a, both flags 0.
  - clip_hi and clip_lo are never both set.
- Pipeline: two register stages.
  - S1 registers the compare results and the input sample.
  - S2 registers the muxed output and the flags.
  - Latency is 2 cycles from input handshake to out_valid when unstalled; throughput is 1 beat per cycle.
  - A stage loads when it is empty or its contents move on in the same cycle.
  - in_ready = !s1_valid || (s1 moves into s2 this cycle). in_ready is combinational from out_ready (no skid buffer).
  - While out_valid && !out_ready: out_data, out_clip_hi and out_clip_lo are held stable, and no beat is lost or duplicated.
- Counters:
  - For lane k, cnt_hi[k] increments on the output handshake (out_valid && out_ready) when out_clip_hi[k] is set. cnt_lo[k] behaves the same way with out_clip_lo[k].
  - Counters saturate at all-ones and do not wrap.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
  - cnt_hi/cnt_lo readback is combinational from cnt_sel.
  - cnt_sel >= P_NCH reads 0.
- Reset mid-operation: all pipeline contents are discarded and in-flight beats are dropped. Active limits return to pass-through.

Decomposition:
- Package clip_pkg:
  - Constant functions for signed min/max of a given width.
  - clog2 helper.
  - Lane packing/unpacking index macros or functions.
- Sub-module clip_lane (one per lane, generate loop): S1 compare plus S2 mux and flag registers for a single lane, with stage enables supplied by the top.
- The top module holds:
  - the handshake control;
  - the limit registers and validation;
  - the counter array and readback mux.

Test Plan:
1. Reset, then send 1 beat, P_WIDTH=16, lanes {0x7FFF, 0x8000, 0, -1}, no lim_wr -> after 2 cycles, out_data is identical to the input and all flags are 0.
2. lim_wr with lo=-100, hi=100, then send lanes {150, -150, 100, -101} -> output {100, -100, 100, -100}, out_clip_hi=0001, out_clip_lo=1010.
3. lim_wr with lo=50, hi=-50 -> lim_err pulses for 1 cycle, and the limits from scenario 2 stay active (verified by re-sending the scenario 2 beat).
4. Stream 20 beats with random out_ready (~50%) and lo=-10, hi=10 -> scoreboard sees every beat in order, with no loss or duplicates, and outputs stable whenever stalled.
5. P_CNT_WIDTH=4, lane 0 clips high on 20 beats -> cnt_hi with cnt_sel=0 reads 15 (saturated). Asserting cnt_clr together with a clipping handshake -> reads 0 on the next cycle.
6. Assert rst_n low while 2 beats are in flight -> out_valid drops immediately, no stale beat emerges after release, and the limits read back as pass-through.

Source files
------------

// File: rtl/clip_pkg.sv
// Shared helpers for the signed stream clipper: limit constants, select width
// and lane packing offsets.
package clip_pkg;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Bit patterns of the most negative / most positive w-bit two's complement value.
    function automatic logic [63:0] smin_bits(input int w);
        return {64{1'b1}} << (w - 1);
    endfunction

    function automatic logic [63:0] smax_bits(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/clip_lane.sv
// One lane of the clipper: S1 compares against the active limits, S2 muxes
// the clipped value and registers the flags.
module clip_lane #(
    parameter int P_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s1_en,
    input  logic                      s2_en,
    input  logic signed [P_WIDTH-1:0] a_i,
    input  logic signed [P_WIDTH-1:0] lo_i,
    input  logic signed [P_WIDTH-1:0] hi_i,
    output logic signed [P_WIDTH-1:0] y_o,
    output logic                      clip_hi_o,
    output logic                      clip_lo_o
);

    logic                      gt_d;
    logic                      lt_d;
    logic                      gt_q;
    logic                      lt_q;
    logic signed [P_WIDTH-1:0] a_q;
    logic signed [P_WIDTH-1:0] lim_q;
    logic signed [P_WIDTH-1:0] y_q;
    logic                      clip_hi_q;
    logic                      clip_lo_q;

    // The limit value is captured with the compare so a limit change between
    // S1 and S2 cannot mix old compare results with new limit values.
    assign gt_d = a_i > hi_i;
    assign lt_d = (a_i < lo_i) && !gt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            a_q       <= '0;
            lim_q     <= '0;
            y_q       <= '0;
            clip_hi_q <= 1'b0;
            clip_lo_q <= 1'b0;
        end else begin
            if (s1_en) begin
                gt_q  <= gt_d;
                lt_q  <= lt_d;
                a_q   <= a_i;
                lim_q <= gt_d ? hi_i : lo_i;
            end
            if (s2_en) begin
                y_q       <= (gt_q || lt_q) ? lim_q : a_q;
                clip_hi_q <= gt_q;
                clip_lo_q <= lt_q;
            end
        end
    end

    assign y_o       = y_q;
    assign clip_hi_o = clip_hi_q;
    assign clip_lo_o = clip_lo_q;

endmodule

// File: rtl/clip_signed_stream.sv
// Multi-lane pipelined signed clipper with valid/ready on both sides,
// programmable shared limits and per-lane saturating clip-event counters.
module clip_signed_stream
    import clip_pkg::*;
#(
    parameter int P_WIDTH     = 16,
    parameter int P_NCH       = 4,
    parameter int P_CNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic signed [P_WIDTH-1:0]        lim_lo,
    input  logic signed [P_WIDTH-1:0]        lim_hi,
    input  logic                             lim_wr,
    output logic                             lim_err,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [P_NCH*P_WIDTH-1:0]         in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [P_NCH*P_WIDTH-1:0]         out_data,
    output logic [P_NCH-1:0]                 out_clip_hi,
    output logic [P_NCH-1:0]                 out_clip_lo,
    input  logic [clog2_min1(P_NCH)-1:0]     cnt_sel,
    output logic [P_CNT_WIDTH-1:0]           cnt_hi,
    output logic [P_CNT_WIDTH-1:0]           cnt_lo,
    input  logic                             cnt_clr
);

    localparam logic signed [P_WIDTH-1:0] LIM_MIN = P_WIDTH'(smin_bits(P_WIDTH));
    localparam logic signed [P_WIDTH-1:0] LIM_MAX = P_WIDTH'(smax_bits(P_WIDTH));

    logic                      s1_valid_q;
    logic                      s2_valid_q;
    logic                      s2_free;
    logic                      s1_move;
    logic                      s1_load;
    logic                      out_hs;
    logic signed [P_WIDTH-1:0] lo_q;
    logic signed [P_WIDTH-1:0] hi_q;
    logic                      lim_ok;
    logic                      lim_err_q;
    logic [P_CNT_WIDTH-1:0]    cnt_hi_q [P_NCH];
    logic [P_CNT_WIDTH-1:0]    cnt_lo_q [P_NCH];

    // Handshake: S2 frees up when empty or being drained; S1 follows S2.
    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_move  = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign s1_load  = in_valid && in_ready;
    assign out_hs   = s2_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (s2_free)  s2_valid_q <= s1_valid_q;
        end
    end

    assign lim_ok = lim_lo <= lim_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q      <= LIM_MIN;
            hi_q      <= LIM_MAX;
            lim_err_q <= 1'b0;
        end else begin
            if (lim_wr && lim_ok) begin
                lo_q <= lim_lo;
                hi_q <= lim_hi;
            end
            lim_err_q <= lim_wr && !lim_ok;
        end
    end

    for (genvar k = 0; k < P_NCH; k++) begin : g_lane
        clip_lane #(.P_WIDTH(P_WIDTH)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .s1_en     (s1_load),
            .s2_en     (s1_move),
            .a_i       (in_data[lane_lsb(k, P_WIDTH) +: P_WIDTH]),
            .lo_i      (lo_q),
            .hi_i      (hi_q),
            .y_o       (out_data[lane_lsb(k, P_WIDTH) +: P_WIDTH]),
            .clip_hi_o (out_clip_hi[k]),
            .clip_lo_o (out_clip_lo[k])
        );
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < P_NCH; k++) begin
                cnt_hi_q[k] <= '0;
                cnt_lo_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < P_NCH; k++) begin
                if (cnt_clr) begin
                    cnt_hi_q[k] <= '0;
                    cnt_lo_q[k] <= '0;
                end else if (out_hs) begin
                    if (out_clip_hi[k] && (cnt_hi_q[k] != '1))
                        cnt_hi_q[k] <= cnt_hi_q[k] + P_CNT_WIDTH'(1);
                    if (out_clip_lo[k] && (cnt_lo_q[k] != '1))
                        cnt_lo_q[k] <= cnt_lo_q[k] + P_CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_hi = '0;
        cnt_lo = '0;
        if (int'(cnt_sel) < P_NCH) begin
            cnt_hi = cnt_hi_q[cnt_sel];
            cnt_lo = cnt_lo_q[cnt_sel];
        end
    end

    assign out_valid = s2_valid_q;
    assign lim_err   = lim_err_q;

endmodule

// File: tb/tb_clip_signed_stream.sv
// Directed-vector bench for clip_signed_stream: table of limit/beat/expected
// records plus hand-written sequences for stalls, counters and reset.
module tb_clip_signed_stream;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int CW = 4;

    logic                 clk;
    logic                 rst_n;
    logic signed [W-1:0]  lim_lo;
    logic signed [W-1:0]  lim_hi;
    logic                 lim_wr;
    logic                 lim_err;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*W-1:0]       in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*W-1:0]       out_data;
    logic [N-1:0]         out_clip_hi;
    logic [N-1:0]         out_clip_lo;
    logic [1:0]           cnt_sel;
    logic [CW-1:0]        cnt_hi;
    logic [CW-1:0]        cnt_lo;
    logic                 cnt_clr;

    int n_vec = 0;
    int n_err = 0;

    clip_signed_stream #(.P_WIDTH(W), .P_NCH(N), .P_CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lim_lo      (lim_lo),
        .lim_hi      (lim_hi),
        .lim_wr      (lim_wr),
        .lim_err     (lim_err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_clip_hi (out_clip_hi),
        .out_clip_lo (out_clip_lo),
        .cnt_sel     (cnt_sel),
        .cnt_hi      (cnt_hi),
        .cnt_lo      (cnt_lo),
        .cnt_clr     (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          lo;
        int          hi;
        logic [63:0] din;
        logic [63:0] dout;
        logic [3:0]  eh;
        logic [3:0]  el;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Reference clipper used for the random stream.
    task automatic model(input logic [63:0] din, input int lo, input int hi,
                         output logic [63:0] y, output logic [3:0] fh, output logic [3:0] fl);
        int a;
        y  = '0;
        fh = '0;
        fl = '0;
        for (int k = 0; k < N; k++) begin
            a = int'($signed(din[k*16 +: 16]));
            if (a > hi) begin
                y[k*16 +: 16] = 16'(hi);
                fh[k] = 1'b1;
            end else if (a < lo) begin
                y[k*16 +: 16] = 16'(lo);
                fl[k] = 1'b1;
            end else begin
                y[k*16 +: 16] = 16'(a);
            end
        end
    endtask

    task automatic lim_write(input int lo, input int hi);
        lim_lo = 16'(lo);
        lim_hi = 16'(hi);
        lim_wr = 1'b1;
        step();
        lim_wr = 1'b0;
    endtask

    task automatic send_and_check(input string nm, input logic [63:0] din, input logic [63:0] ed,
                                  input logic [3:0] eh, input logic [3:0] el);
        int t;
        in_data   = din;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        step();
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            step();
            t++;
        end
        chk({nm, " valid"}, 64'(out_valid), 64'd1);
        chk({nm, " data"}, out_data, ed);
        chk({nm, " clip_hi"}, 64'(out_clip_hi), 64'(eh));
        chk({nm, " clip_lo"}, 64'(out_clip_lo), 64'(el));
        step();
    endtask

    task automatic stream_n(input logic [63:0] din, input int n);
        in_data   = din;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    vec_t tbl[4];

    initial begin
        logic [63:0] expq[$];
        logic [3:0]  ehq[$];
        logic [3:0]  elq[$];
        logic [63:0] y;
        logic [3:0]  fh;
        logic [3:0]  fl;
        logic [63:0] hold_d;
        logic [3:0]  hold_h;
        logic [3:0]  hold_l;
        logic        stalled;
        logic        accepted;
        int          sent;
        int          got;
        int          cyc;
        int          seen;

        tbl[0] = '{lo: -100,   hi: 100,   din: pack4(150, -150, 100, -101),
                   dout: pack4(100, -100, 100, -100), eh: 4'b0001, el: 4'b1010};
        tbl[1] = '{lo: 5,      hi: 5,     din: pack4(0, 5, -7, 100),
                   dout: pack4(5, 5, 5, 5),           eh: 4'b1000, el: 4'b0101};
        tbl[2] = '{lo: -32768, hi: 32767, din: pack4(-32768, 32767, 1, -1),
                   dout: pack4(-32768, 32767, 1, -1), eh: 4'b0000, el: 4'b0000};
        tbl[3] = '{lo: -1,     hi: 0,     din: pack4(-2, 1, 0, -1),
                   dout: pack4(-1, 0, 0, -1),         eh: 4'b0010, el: 4'b0001};

        rst_n     = 1'b0;
        lim_lo    = '0;
        lim_hi    = '0;
        lim_wr    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cnt_sel   = '0;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_data", out_data, 64'd0);
        chk("rst flags", 64'({out_clip_hi, out_clip_lo}), 64'd0);
        chk("rst lim_err", 64'(lim_err), 64'd0);
        chk("rst cnt", 64'({cnt_hi, cnt_lo}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Pass-through at reset limits, with exact 2-cycle latency.
        in_data  = pack4(32767, -32768, 0, -1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1 lat1 valid", 64'(out_valid), 64'd0);
        step();
        chk("t1 lat2 valid", 64'(out_valid), 64'd1);
        chk("t1 data", out_data, pack4(32767, -32768, 0, -1));
        chk("t1 flags", 64'({out_clip_hi, out_clip_lo}), 64'd0);
        step();
        chk("t1 drained", 64'(out_valid), 64'd0);

        for (int i = 0; i < 4; i++) begin
            lim_write(tbl[i].lo, tbl[i].hi);
            chk($sformatf("vec%0d lim_err", i), 64'(lim_err), 64'd0);
            send_and_check($sformatf("vec%0d", i), tbl[i].din, tbl[i].dout, tbl[i].eh, tbl[i].el);
        end

        // Rejected limit write keeps the previous limits.
        lim_write(-100, 100);
        lim_write(50, -50);
        chk("t3 lim_err pulse", 64'(lim_err), 64'd1);
        step();
        chk("t3 lim_err clear", 64'(lim_err), 64'd0);
        send_and_check("t3 old limits", tbl[0].din, tbl[0].dout, tbl[0].eh, tbl[0].el);

        // Random backpressure stream.
        lim_write(-10, 10);
        sent     = 0;
        got      = 0;
        cyc      = 0;
        stalled  = 1'b0;
        hold_d   = '0;
        hold_h   = '0;
        hold_l   = '0;
        in_data  = pack4($urandom_range(0, 60) - 30, $urandom_range(0, 60) - 30,
                         $urandom_range(0, 60) - 30, $urandom_range(0, 60) - 30);
        while (got < 20 && cyc < 1000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 20);
            #1;
            if (stalled) begin
                chk("t4 stall valid", 64'(out_valid), 64'd1);
                chk("t4 stall data", out_data, hold_d);
                chk("t4 stall flags", 64'({out_clip_hi, out_clip_lo}), 64'({hold_h, hold_l}));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("t4 extra beat", 64'd1, 64'd0 + 64'(expq.size()));
                end else begin
                    chk("t4 data", out_data, expq.pop_front());
                    chk("t4 clip_hi", 64'(out_clip_hi), 64'(ehq.pop_front()));
                    chk("t4 clip_lo", 64'(out_clip_lo), 64'(elq.pop_front()));
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            hold_d  = out_data;
            hold_h  = out_clip_hi;
            hold_l  = out_clip_lo;
            accepted = in_valid && in_ready;
            if (accepted) begin
                model(in_data, -10, 10, y, fh, fl);
                expq.push_back(y);
                ehq.push_back(fh);
                elq.push_back(fl);
                sent++;
            end
            step();
            if (accepted)
                in_data = pack4($urandom_range(0, 60) - 30, $urandom_range(0, 60) - 30,
                                $urandom_range(0, 60) - 30, $urandom_range(0, 60) - 30);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("t4 beats received", 64'(got), 64'd20);
        chk("t4 beats sent", 64'(sent), 64'd20);
        repeat (3) step();
        chk("t4 no extra", 64'(out_valid), 64'd0);

        // Counters: increment, saturate, clear priority.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        cnt_sel = 2'd0;
        #1;
        chk("t5 cleared", 64'({cnt_hi, cnt_lo}), 64'd0);
        stream_n(pack4(100, -100, 0, 0), 3);
        cnt_sel = 2'd0;
        #1;
        chk("t5 lane0 hi=3", 64'(cnt_hi), 64'd3);
        chk("t5 lane0 lo=0", 64'(cnt_lo), 64'd0);
        cnt_sel = 2'd1;
        #1;
        chk("t5 lane1 lo=3", 64'(cnt_lo), 64'd3);
        stream_n(pack4(100, -100, 0, 0), 20);
        cnt_sel = 2'd0;
        #1;
        chk("t5 lane0 hi sat", 64'(cnt_hi), 64'd15);
        cnt_sel = 2'd1;
        #1;
        chk("t5 lane1 lo sat", 64'(cnt_lo), 64'd15);
        chk("t5 lane1 hi", 64'(cnt_hi), 64'd0);
        cnt_sel = 2'd2;
        #1;
        chk("t5 lane2 idle", 64'({cnt_hi, cnt_lo}), 64'd0);
        in_data  = pack4(100, -100, 0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("t5 hs pending", 64'(out_valid), 64'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        cnt_sel = 2'd0;
        #1;
        chk("t5 clr priority hi", 64'(cnt_hi), 64'd0);
        cnt_sel = 2'd1;
        #1;
        chk("t5 clr priority lo", 64'(cnt_lo), 64'd0);

        // Reset with two beats in flight.
        lim_write(-100, 100);
        out_ready = 1'b0;
        in_data   = pack4(150, 0, 0, 0);
        in_valid  = 1'b1;
        step();
        in_data = pack4(-150, 0, 0, 0);
        step();
        in_valid = 1'b0;
        chk("t6 in flight", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async drop", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen      = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen++;
        end
        chk("t6 no stale beat", 64'(seen), 64'd0);
        send_and_check("t6 pass-through", pack4(32767, -32768, 200, -200),
                       pack4(32767, -32768, 200, -200), 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
